// File: rtl/wb_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wb_arb_pkg : shared state encoding and helpers for wb_port_arbiter  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package wb_arb_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE  = 2'd0;
   localparam state_t GRANT = 2'd1;
   localparam state_t BUSY  = 2'd2;

   localparam int c_MIN_PORTS = 2;
   localparam int c_MAX_PORTS = 8;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

endpackage : wb_arb_pkg
`default_nettype wire

// File: rtl/wb_rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wb_rr_pick : combinational round-robin picker, search from last+1   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module wb_rr_pick
   import wb_arb_pkg::*;
#(
   parameter int NR_OF_PORTS = 4,
   parameter int ID_W        = 2
) (
   input  logic [NR_OF_PORTS-1:0] req_i,
   input  logic [ID_W-1:0]        last_i,
   output logic [NR_OF_PORTS-1:0] win_oh_o,
   output logic [ID_W-1:0]        win_id_o,
   output logic                   valid_o
);

   logic [ID_W:0]   sum_d;
   logic [ID_W-1:0] idx_d;

   // Walk from farthest to nearest so the port closest to last+1 overwrites.
   always_comb begin
      win_oh_o = '0;
      win_id_o = '0;
      valid_o  = 1'b0;
      sum_d    = '0;
      idx_d    = '0;
      for (int k = NR_OF_PORTS; k >= 1; k--) begin
         sum_d = {1'b0, last_i} + (ID_W+1)'(k);
         if (sum_d >= (ID_W+1)'(NR_OF_PORTS)) begin
            sum_d = sum_d - (ID_W+1)'(NR_OF_PORTS);
         end
         idx_d = sum_d[ID_W-1:0];
         if (req_i[idx_d]) begin
            win_oh_o        = '0;
            win_oh_o[idx_d] = 1'b1;
            win_id_o        = idx_d;
            valid_o         = 1'b1;
         end
      end
   end

endmodule : wb_rr_pick
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wb_port_arbiter : round-robin owner of the shared SDRAM FIFO path   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module wb_port_arbiter
   import wb_arb_pkg::*;
#(
   parameter int NR_OF_PORTS = 4,
   parameter int ID_W        = 2
) (
   input  logic                   wb_clk,
   input  logic                   wb_rst,
   input  logic [NR_OF_PORTS-1:0] req_i,
   input  logic [NR_OF_PORTS-1:0] idle_i,
   input  logic                   ext_stall_i,
   output logic [NR_OF_PORTS-1:0] stall_o,
   output logic [NR_OF_PORTS-1:0] grant_o,
   output logic [ID_W-1:0]        grant_id_o,
   output logic                   busy_o
);

   generate
      if ((ID_W != clog2(NR_OF_PORTS)) ||
          (NR_OF_PORTS < c_MIN_PORTS) || (NR_OF_PORTS > c_MAX_PORTS)) begin : g_param_check
         $error("wb_port_arbiter: NR_OF_PORTS must be 2..8 and ID_W = clog2(NR_OF_PORTS)");
      end
   endgenerate

   state_t                   state_q;
   logic [NR_OF_PORTS-1:0]   grant_q;
   logic [ID_W-1:0]          grant_id_q;
   logic [ID_W-1:0]          last_q;
   logic                     busy_q;

   logic [NR_OF_PORTS-1:0]   win_oh_d;
   logic [ID_W-1:0]          win_id_d;
   logic                     win_vld_d;

   wb_rr_pick #(
      .NR_OF_PORTS (NR_OF_PORTS),
      .ID_W        (ID_W)
   ) u_pick (
      .req_i    (req_i),
      .last_i   (last_q),
      .win_oh_o (win_oh_d),
      .win_id_o (win_id_d),
      .valid_o  (win_vld_d)
   );

   // grant_id_q is left holding the last owner on release; only grant_o marks ownership.
   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         grant_id_q <= '0;
         last_q     <= ID_W'(NR_OF_PORTS - 1);
         busy_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (win_vld_d && !ext_stall_i) begin
                  grant_q    <= win_oh_d;
                  grant_id_q <= win_id_d;
                  busy_q     <= 1'b1;
                  state_q    <= GRANT;
               end
            end
            GRANT: begin
               if (!idle_i[grant_id_q]) begin
                  state_q <= BUSY;
               end else if (!req_i[grant_id_q]) begin
                  grant_q <= '0;
                  last_q  <= grant_id_q;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            BUSY: begin
               if (idle_i[grant_id_q]) begin
                  grant_q <= '0;
                  last_q  <= grant_id_q;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: begin
               grant_q <= '0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Combinational so an SDRAM-side stall hits the owner in the same cycle.
   assign stall_o    = ~grant_q | {NR_OF_PORTS{ext_stall_i}};
   assign grant_o    = grant_q;
   assign grant_id_o = grant_id_q;
   assign busy_o     = busy_q;

endmodule : wb_port_arbiter
`default_nettype wire
